mc_control: RTL and testbench

Multicycle control sequencer for the 32-bit MIPS datapath. It replaces the single-cycle combinational control with a Moore FSM that reuses one ALU and one unified memory across several cycles per instruction. It decodes the 6-bit opcode, drives all datapath mux selects and write strobes, and stalls on a memory-ready handshake. It sits between the instruction register and the shared PC/memory/ALU/register-bank datapath.

---
 rtl/mc_control.sv | 195 +++++++++++++++++++
 tb/tb_mc_control.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle control sequencer for the 32-bit MIPS datapath: a Moore FSM that
// steps one shared ALU and one unified memory through each instruction.
module mc_control #(
    parameter int OP_WIDTH = 6,
    parameter int ST_WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OP_WIDTH-1:0] Op,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                Retire,
    output logic                Illegal,
    output logic [ST_WIDTH-1:0] State
);

    localparam logic [ST_WIDTH-1:0] FETCH  = ST_WIDTH'(0);
    localparam logic [ST_WIDTH-1:0] DECODE = ST_WIDTH'(1);
    localparam logic [ST_WIDTH-1:0] MEMADR = ST_WIDTH'(2);
    localparam logic [ST_WIDTH-1:0] MEMRD  = ST_WIDTH'(3);
    localparam logic [ST_WIDTH-1:0] MEMWB  = ST_WIDTH'(4);
    localparam logic [ST_WIDTH-1:0] MEMWR  = ST_WIDTH'(5);
    localparam logic [ST_WIDTH-1:0] EXEC   = ST_WIDTH'(6);
    localparam logic [ST_WIDTH-1:0] RWB    = ST_WIDTH'(7);
    localparam logic [ST_WIDTH-1:0] BRANCH = ST_WIDTH'(8);
    localparam logic [ST_WIDTH-1:0] JUMP   = ST_WIDTH'(9);
    localparam logic [ST_WIDTH-1:0] ADDIEX = ST_WIDTH'(10);
    localparam logic [ST_WIDTH-1:0] ADDIWB = ST_WIDTH'(11);

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);

    logic [ST_WIDTH-1:0] nextState;
    logic                opLegal;

    assign opLegal = (Op == OP_RTYPE) || (Op == OP_J)  || (Op == OP_BEQ) ||
                     (Op == OP_ADDI)  || (Op == OP_LW) || (Op == OP_SW);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            State <= FETCH;
        end else begin
            State <= nextState;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nextState = FETCH;
        case (State)
            FETCH:  nextState = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDIEX;
                    default:      nextState = FETCH;
                endcase
            end
            // Op comes from the instruction register and is stable here.
            MEMADR: nextState = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = MemReady ? MEMWB : MEMRD;
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = MemReady ? FETCH : MEMWR;
            EXEC:   nextState = RWB;
            RWB:    nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
            ADDIEX: nextState = ADDIWB;
            ADDIWB: nextState = FETCH;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        Retire      = 1'b0;
        Illegal     = 1'b0;
        case (State)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = !opLegal;
                Retire  = !opLegal;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                Retire   = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Retire   = MemReady;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                Retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Retire      = 1'b1;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                Retire   = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            default: ;
        endcase

        // Reset kills every strobe immediately so an abandoned instruction
        // cannot write anything; the datapath selects idle at their FETCH values.
        if (RST) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b01;
            ALUOp       = 3'b000;
            PCSource    = 2'b00;
            Retire      = 1'b0;
            Illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: randomized instruction streams compared
// against a per-instruction cycle-sequence model of the multicycle control.
module tb_mc_control;

    logic       CLK;
    logic       RST;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       Retire, Illegal;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    mc_control dut (
        .CLK(CLK), .RST(RST), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Retire(Retire), .Illegal(Illegal), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic ctrl_t observed();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Retire, Illegal};
    endfunction

    // Control word the datapath should see in a given step of an instruction.
    function automatic ctrl_t expCtrl(int st, bit rdy, bit ill);
        ctrl_t c = '0;
        case (st)
            0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
            1:  begin c.aluSrcB = 2'b11; c.illegal = ill; c.retire = ill; end
            2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            3:  begin c.memRead = 1; c.iorD = 1; end
            4:  begin c.regWrite = 1; c.memtoReg = 1; c.retire = 1; end
            5:  begin c.memWrite = 1; c.iorD = 1; c.retire = rdy; end
            6:  begin c.aluSrcA = 1; c.aluOp = 3'b010; end
            7:  begin c.regWrite = 1; c.regDst = 1; c.retire = 1; end
            8:  begin c.aluSrcA = 1; c.aluOp = 3'b001; c.pcWriteCond = 1; c.pcSource = 2'b01; c.retire = 1; end
            9:  begin c.pcWrite = 1; c.pcSource = 2'b10; c.retire = 1; end
            10: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            11: begin c.regWrite = 1; c.retire = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t resetCtrl();
        ctrl_t c = '0;
        c.aluSrcB = 2'b01;
        return c;
    endfunction

    function automatic int baseLatency(logic [5:0] op);
        case (op)
            OP_LW:                     return 5;
            OP_SW, OP_RTYPE, OP_ADDI:  return 4;
            OP_BEQ, OP_J:              return 3;
            default:                   return 2;
        endcase
    endfunction

    function automatic logic [5:0] randIllegalOp();
        logic [5:0] op;
        do op = 6'($urandom);
        while (op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
        return op;
    endfunction

    // Runs one instruction from FETCH, checking every cycle. stopAfter > 0
    // abandons it after that many cycles (used to inject a reset mid-flight).
    task automatic runInstr(input logic [5:0] op, input int fStall, input int mStall,
                            input int stopAfter, input string name, output int retires);
        int  seq[$];
        bit  rdyQ[$];
        bit  ill;
        int  steps;
        int  retireAt;
        int  expLat;
        ctrl_t obs, exp;
        ill = 0;
        for (int i = 0; i < fStall; i++) begin seq.push_back(0); rdyQ.push_back(0); end
        seq.push_back(0); rdyQ.push_back(1);
        seq.push_back(1); rdyQ.push_back(1'($urandom));
        case (op)
            OP_LW: begin
                seq.push_back(2); rdyQ.push_back(1'($urandom));
                for (int i = 0; i < mStall; i++) begin seq.push_back(3); rdyQ.push_back(0); end
                seq.push_back(3); rdyQ.push_back(1);
                seq.push_back(4); rdyQ.push_back(1'($urandom));
            end
            OP_SW: begin
                seq.push_back(2); rdyQ.push_back(1'($urandom));
                for (int i = 0; i < mStall; i++) begin seq.push_back(5); rdyQ.push_back(0); end
                seq.push_back(5); rdyQ.push_back(1);
            end
            OP_RTYPE: begin seq.push_back(6); rdyQ.push_back(1'($urandom)); seq.push_back(7); rdyQ.push_back(1'($urandom)); end
            OP_BEQ:   begin seq.push_back(8); rdyQ.push_back(1'($urandom)); end
            OP_J:     begin seq.push_back(9); rdyQ.push_back(1'($urandom)); end
            OP_ADDI:  begin seq.push_back(10); rdyQ.push_back(1'($urandom)); seq.push_back(11); rdyQ.push_back(1'($urandom)); end
            default:  ill = 1;
        endcase
        expLat = baseLatency(op) + fStall + ((op == OP_LW || op == OP_SW) ? mStall : 0);
        steps = (stopAfter > 0 && stopAfter < seq.size()) ? stopAfter : seq.size();
        retires = 0;
        retireAt = -1;
        for (int i = 0; i < steps; i++) begin
            Op = (seq[i] == 0) ? 6'($urandom) : op;
            MemReady = rdyQ[i];
            #4;
            obs = observed();
            exp = expCtrl(seq[i], rdyQ[i], ill);
            checks++;
            if (State !== 4'(seq[i])) begin
                errors++;
                $display("FAIL %s state step %0d: got %0d expected %0d", name, i, State, seq[i]);
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s ctrl step %0d state %0d: got %h expected %h", name, i, seq[i], obs, exp);
            end
            checks++;
            if ((MemRead && MemWrite) || (PCWrite && PCWriteCond)) begin
                errors++;
                $display("FAIL %s exclusive strobes step %0d: got rd/wr=%b%b pcw/cond=%b%b expected not both",
                         name, i, MemRead, MemWrite, PCWrite, PCWriteCond);
            end
            if (Retire === 1'b1) begin
                retires++;
                if (retireAt < 0) retireAt = i + 1;
            end
            @(posedge CLK); #1;
        end
        if (stopAfter <= 0) begin
            checks++;
            if (retireAt != expLat || retires != 1) begin
                errors++;
                $display("FAIL %s latency: got retire at cycle %0d (%0d pulses) expected cycle %0d (1 pulse)",
                         name, retireAt, retires, expLat);
            end
        end
    endtask

    task automatic test_reset();
        int r;
        RST = 1; MemReady = 1; Op = 6'($urandom);
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if (observed() !== resetCtrl()) begin
                errors++;
                $display("FAIL reset ctrl cycle %0d: got %h expected %h", i, observed(), resetCtrl());
            end
            if (i == 1) begin
                checks++;
                if (State !== 4'd0) begin
                    errors++;
                    $display("FAIL reset state: got %0d expected 0", State);
                end
            end
            @(posedge CLK); #1;
        end
        RST = 0;
        runInstr(OP_ADDI, 0, 0, 0, "post_reset_addi", r);
    endtask

    task automatic test_rtype();
        int r;
        runInstr(OP_RTYPE, 0, 0, 0, "rtype", r);
    endtask

    task automatic test_lw_stall();
        int r;
        runInstr(OP_LW, 0, 3, 0, "lw_memrd_stall", r);
    endtask

    task automatic test_sw_fetch_stall();
        int r;
        runInstr(OP_SW, 2, 0, 0, "sw_fetch_stall", r);
        runInstr(OP_SW, 1, 3, 0, "sw_memwr_stall", r);
    endtask

    task automatic test_branch_jump_illegal();
        int r1, r2, r3;
        runInstr(OP_BEQ, 0, 0, 0, "beq", r1);
        runInstr(OP_J, 0, 0, 0, "j", r2);
        runInstr(6'b111111, 0, 0, 0, "illegal_3f", r3);
        checks++;
        if (r1 + r2 + r3 != 3) begin
            errors++;
            $display("FAIL retire_total: got %0d expected 3", r1 + r2 + r3);
        end
    endtask

    task automatic test_reset_mid_write();
        int r;
        runInstr(OP_SW, 0, 5, 5, "sw_abandoned", r);
        RST = 1; MemReady = 0; Op = OP_SW;
        #4;
        checks++;
        if (State !== 4'd5) begin
            errors++;
            $display("FAIL reset_mid_write pre-edge state: got %0d expected 5", State);
        end
        checks++;
        if (observed() !== resetCtrl()) begin
            errors++;
            $display("FAIL reset_mid_write ctrl: got %h expected %h", observed(), resetCtrl());
        end
        @(posedge CLK); #1;
        RST = 0;
        runInstr(OP_RTYPE, 0, 0, 0, "after_reset_rtype", r);
        runInstr(OP_LW, 1, 1, 0, "after_reset_lw", r);
        runInstr(OP_SW, 0, 1, 0, "after_reset_sw", r);
    endtask

    task automatic test_random();
        logic [5:0] pool [7];
        logic [5:0] op;
        int r;
        pool = '{OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, 6'b000000};
        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 6);
            op = (k == 6) ? randIllegalOp() : pool[k];
            runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0,
                     $sformatf("random_%0d_op%02h", n, op), r);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_fetch_stall();
        test_branch_jump_illegal();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
